// File: rtl/pwm_breather_if.sv
// pwm_breather_if: tick/enable inputs and PWM/ramp status outputs of the LED breather.
//   master : drives tick_in, en; observes pwm_out, duty, phase, step_pulse
//   slave  : the breather itself
//   tick_in     slow toggle, each edge is one tick
//   en          1 = run, 0 = freeze ramp and force pwm_out low
//   pwm_out     registered PWM output
//   duty        current duty value
//   phase       ramp state: 0 up, 1 hold high, 2 down, 3 hold low
//   step_pulse  one-cycle pulse in the cycle after an accepted tick
interface pwm_breather_if #(
    parameter int unsigned PWM_BITS = 8
);
    logic                tick_in;
    logic                en;
    logic                pwm_out;
    logic [PWM_BITS-1:0] duty;
    logic [1:0]          phase;
    logic                step_pulse;

    modport master (
        output tick_in, en,
        input  pwm_out, duty, phase, step_pulse
    );

    modport slave (
        input  tick_in, en,
        output pwm_out, duty, phase, step_pulse
    );
endinterface

// File: rtl/pwm_breather.sv
// pwm_breather: turns edges of a slow toggle into a triangle-wave duty ramp
// (up, hold high, down, hold low) and drives an LED with a PWM of that duty.
//   clk   system clock
//   res   synchronous reset, active-high
//   bus   pwm_breather_if slave: tick_in, en in; pwm_out, duty, phase, step_pulse out
module pwm_breather #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 4
) (
    input logic           clk,
    input logic           res,
    pwm_breather_if.slave bus
);
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [PWM_BITS:0]   DMAX_X    = {1'b0, DMAX};
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        StRampUp = 2'd0,
        StHoldHi = 2'd1,
        StRampDn = 2'd2,
        StHoldLo = 2'd3
    } state_e;

    state_e              state;
    logic [PWM_BITS-1:0] duty_q;
    logic [HW-1:0]       hold_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_q;
    logic                step_q;
    logic                tick_q;

    logic                step;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    always_comb begin
        step = bus.en & (bus.tick_in ^ tick_q);
        // One extra bit so saturation at DMAX cannot be masked by wrap-around.
        up_sum  = {1'b0, duty_q} + STEP_X;
        duty_up = (up_sum > DMAX_X) ? DMAX : up_sum[PWM_BITS-1:0];
        duty_dn = (duty_q > STEP_N) ? (duty_q - STEP_N) : '0;
    end

    always_ff @(posedge clk) begin
        // Tracks tick_in even in reset and while disabled, so stale edges never count.
        tick_q  <= bus.tick_in;
        pwm_cnt <= pwm_cnt + 1'b1;
        if (res) begin
            state    <= StRampUp;
            duty_q   <= '0;
            hold_cnt <= '0;
            pwm_cnt  <= '0;
            pwm_q    <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            step_q <= step;
            pwm_q  <= bus.en & (pwm_cnt < duty_q);
            if (step) begin
                unique case (state)
                    StRampUp: begin
                        duty_q <= duty_up;
                        if (duty_up == DMAX) begin
                            state    <= StHoldHi;
                            hold_cnt <= '0;
                        end
                    end
                    StHoldHi: begin
                        if (hold_cnt == HOLD_LAST) state <= StRampDn;
                        else                       hold_cnt <= hold_cnt + 1'b1;
                    end
                    StRampDn: begin
                        duty_q <= duty_dn;
                        if (duty_dn == '0) begin
                            state    <= StHoldLo;
                            hold_cnt <= '0;
                        end
                    end
                    StHoldLo: begin
                        if (hold_cnt == HOLD_LAST) state <= StRampUp;
                        else                       hold_cnt <= hold_cnt + 1'b1;
                    end
                    default: state <= StRampUp;
                endcase
            end
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.duty       = duty_q;
    assign bus.phase      = state;
    assign bus.step_pulse = step_q;
endmodule

// File: tb/tb_pwm_breather.sv
module tb_pwm_breather;
    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pwm_breather_if #(.PWM_BITS(4)) bus ();

    pwm_breather #(
        .PWM_BITS  (4),
        .STEP      (4),
        .HOLD_TICKS(2)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; returns 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One toggle of tick_in, then check the accepted step and the pulse width.
    task automatic tick(input string tag, input int exp_duty, input int exp_phase);
        bus.tick_in = ~bus.tick_in;
        cyc(1);
        check({tag, " duty"}, int'(bus.duty), exp_duty);
        check({tag, " phase"}, int'(bus.phase), exp_phase);
        check({tag, " pulse"}, int'(bus.step_pulse), 1);
        cyc(1);
        check({tag, " pulse end"}, int'(bus.step_pulse), 0);
    endtask

    // Observe pwm_out over n clocks; report highs and rising transitions.
    task automatic observe(input int n, output int highs, output int rises);
        logic prev;
        highs = 0;
        rises = 0;
        prev  = bus.pwm_out;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (bus.pwm_out) highs++;
            if (bus.pwm_out && !prev) rises++;
            prev = bus.pwm_out;
        end
    endtask

    initial begin
        int highs;
        int rises;
        int pulses;

        // Reset with tick_in high: no tick may appear after release.
        bus.tick_in = 1'b1;
        bus.en      = 1'b1;
        res         = 1'b1;
        cyc(3);
        res = 1'b0;
        cyc(1);
        check("rst duty", int'(bus.duty), 0);
        check("rst phase", int'(bus.phase), 0);
        check("rst pwm", int'(bus.pwm_out), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.step_pulse) pulses++;
            cyc(1);
        end
        check("rst no pulse", pulses, 0);
        observe(20, highs, rises);
        check("duty0 highs", highs, 0);

        // Ramp up with saturation at 15.
        tick("up1", 4, 0);
        tick("up2", 8, 0);
        tick("up3", 12, 0);
        tick("up4", 15, 1);

        // Hold high, ramp down, hold low, back to ramp up.
        tick("hh1", 15, 1);
        tick("hh2", 15, 2);
        tick("dn1", 11, 2);
        tick("dn2", 7, 2);
        tick("dn3", 3, 2);
        tick("dn4", 0, 3);
        tick("hl1", 0, 3);
        tick("hl2", 0, 0);
        tick("up5", 4, 0);

        // PWM at duty 4: 8 highs in 2 runs over 32 clocks.
        observe(32, highs, rises);
        check("pwm4 highs", highs, 8);
        check("pwm4 runs", rises, 2);

        // Disable during ramp up at duty 8; ticks while disabled are dropped.
        tick("up6", 8, 0);
        bus.en = 1'b0;
        cyc(1);
        check("dis pwm", int'(bus.pwm_out), 0);
        for (int i = 0; i < 3; i++) begin
            bus.tick_in = ~bus.tick_in;
            cyc(1);
            check("dis pulse", int'(bus.step_pulse), 0);
            check("dis duty", int'(bus.duty), 8);
            cyc(1);
        end
        observe(16, highs, rises);
        check("dis highs", highs, 0);
        bus.en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (bus.step_pulse) pulses++;
        end
        check("en no step", pulses, 0);
        check("en duty", int'(bus.duty), 8);
        tick("up7", 12, 0);

        // Reach ramp down at duty 7, then pulse reset.
        tick("up8", 15, 1);
        tick("hh3", 15, 1);
        tick("hh4", 15, 2);
        tick("dn5", 11, 2);
        tick("dn6", 7, 2);
        res = 1'b1;
        cyc(1);
        res = 1'b0;
        check("mid rst duty", int'(bus.duty), 0);
        check("mid rst phase", int'(bus.phase), 0);
        check("mid rst pwm", int'(bus.pwm_out), 0);
        cyc(2);
        check("mid rst pulse", int'(bus.step_pulse), 0);
        tick("after rst", 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
